rs_issue_scheduler: RTL and testbench

//  Reservation-station scheduler in front of one functional unit (FU). Accepts

---
 rtl/rs_pkg.sv | 21 ++
 rtl/age_matrix.sv | 61 ++++++
 rtl/rs_issue_scheduler.sv | 151 +++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types and sizes for the reservation-station issue scheduler.
//   RS_ENTRIES / RS_TAG_W / RS_PAYLOAD_W : default geometry of the station
//   CNT_W                                : width of the occupancy counter
//   rs_entry_t                           : one station slot (valid, sources, payload)
package rs_pkg;

   localparam int RS_ENTRIES   = 4;
   localparam int RS_TAG_W     = 4;
   localparam int RS_PAYLOAD_W = 32;
   localparam int CNT_W        = $clog2(RS_ENTRIES + 1);

   typedef struct packed {
      logic                    valid;
      logic [RS_TAG_W-1:0]     src1_tag;
      logic                    src1_rdy;
      logic [RS_TAG_W-1:0]     src2_tag;
      logic                    src2_rdy;
      logic [RS_PAYLOAD_W-1:0] payload;
   } rs_entry_t;

endpackage

// File: rtl/age_matrix.sv
// Age ordering for the station entries.
//   clk_i, reset_i : clock, synchronous active-high reset (clears the matrix)
//   alloc_i        : one-hot entry being allocated this edge (or zero)
//   free_i         : entries being released this edge (any number of bits)
//   valid_i        : currently occupied entries (registered state)
//   req_i          : entries competing for selection
//   grant_o        : one-hot oldest requesting entry (zero if no request)
module age_matrix
   import rs_pkg::*;
#(
   parameter int ENTRIES = RS_ENTRIES
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [ENTRIES-1:0] alloc_i,
   input  logic [ENTRIES-1:0] free_i,
   input  logic [ENTRIES-1:0] valid_i,
   input  logic [ENTRIES-1:0] req_i,
   output logic [ENTRIES-1:0] grant_o
);

   // older_q[i][j] == 1 means entry i was allocated before entry j.
   logic [ENTRIES-1:0] older_q [ENTRIES];
   logic [ENTRIES-1:0] older_d [ENTRIES];

   always_comb begin
      older_d = older_q;
      for (int j = 0; j < ENTRIES; j++) begin
         if (free_i[j]) begin
            for (int i = 0; i < ENTRIES; i++) older_d[i][j] = 1'b0;
         end
      end
      // A new entry is younger than everything already resident and older than nothing.
      for (int k = 0; k < ENTRIES; k++) begin
         if (alloc_i[k]) begin
            older_d[k] = '0;
            for (int j = 0; j < ENTRIES; j++) older_d[j][k] = valid_i[j];
         end
      end
   end

   // An entry wins when no other requesting entry is older than it.
   always_comb begin
      grant_o = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         grant_o[i] = req_i[i];
         for (int j = 0; j < ENTRIES; j++) begin
            if (req_i[j] && older_q[j][i]) grant_o[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < ENTRIES; i++) older_q[i] <= '0;
      end else begin
         older_q <= older_d;
      end
   end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation-station scheduler feeding one functional unit.
//   clk_i, reset_i, flush_i         : clock, sync active-high reset, squash-all
//   alloc_valid_i / alloc_ready_o    : dispatch handshake; alloc_src*_*, alloc_payload_i op fields
//   cdb_valid_i, cdb_tag_i           : result broadcast used to wake waiting sources
//   issue_valid_o / issue_ready_i    : FU handshake; issue_payload_o, issue_entry_o describe the op
//   count_o                          : number of occupied entries
module rs_issue_scheduler
   import rs_pkg::*;
#(
   parameter int ENTRIES   = RS_ENTRIES,
   parameter int TAG_W     = RS_TAG_W,
   parameter int PAYLOAD_W = RS_PAYLOAD_W
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 flush_i,
   input  logic                 alloc_valid_i,
   output logic                 alloc_ready_o,
   input  logic [TAG_W-1:0]     alloc_src1_tag_i,
   input  logic                 alloc_src1_rdy_i,
   input  logic [TAG_W-1:0]     alloc_src2_tag_i,
   input  logic                 alloc_src2_rdy_i,
   input  logic [PAYLOAD_W-1:0] alloc_payload_i,
   input  logic                 cdb_valid_i,
   input  logic [TAG_W-1:0]     cdb_tag_i,
   output logic                 issue_valid_o,
   input  logic                 issue_ready_i,
   output logic [PAYLOAD_W-1:0] issue_payload_o,
   output logic [ENTRIES-1:0]   issue_entry_o,
   output logic [CNT_W-1:0]     count_o
);

   rs_entry_t          entries_q [ENTRIES];
   rs_entry_t          entries_d [ENTRIES];
   logic               lock_q, lock_d;
   logic [ENTRIES-1:0] lock_oh_q, lock_oh_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [ENTRIES-1:0] valid_vec, elig_vec, grant, sel_oh, free_oh, alloc_oh;
   logic               free_found, alloc_fire, issue_fire;

   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         valid_vec[i] = entries_q[i].valid;
         elig_vec[i]  = entries_q[i].valid & entries_q[i].src1_rdy & entries_q[i].src2_rdy;
      end
   end

   // Lowest-index free slot; zero when the station is full.
   always_comb begin
      alloc_oh   = '0;
      free_found = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (!valid_vec[i] && !free_found) begin
            alloc_oh[i] = 1'b1;
            free_found  = 1'b1;
         end
      end
   end

   // Readiness comes from registered occupancy only, so a slot freed by an
   // issue this cycle is not offered to dispatch until the next cycle.
   assign alloc_ready_o = ~&valid_vec;
   assign alloc_fire    = alloc_valid_i & alloc_ready_o & ~flush_i;

   // A stalled presentation stays pinned to its entry until accepted or flushed.
   assign sel_oh          = lock_q ? lock_oh_q : grant;
   assign issue_valid_o   = (|sel_oh) & ~flush_i;
   assign issue_fire      = issue_valid_o & issue_ready_i;
   assign issue_entry_o   = sel_oh;
   assign count_o         = count_q;
   assign free_oh         = flush_i ? '1 : (issue_fire ? sel_oh : '0);

   always_comb begin
      issue_payload_o = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (sel_oh[i]) issue_payload_o = issue_payload_o | entries_q[i].payload;
      end
   end

   age_matrix #(.ENTRIES(ENTRIES)) u_age (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .alloc_i (alloc_oh & {ENTRIES{alloc_fire}}),
      .free_i  (free_oh),
      .valid_i (valid_vec),
      .req_i   (elig_vec),
      .grant_o (grant)
   );

   always_comb begin
      entries_d = entries_q;
      lock_d    = lock_q;
      lock_oh_d = lock_oh_q;
      count_d   = count_q;
      if (flush_i) begin
         for (int i = 0; i < ENTRIES; i++) entries_d[i].valid = 1'b0;
         lock_d    = 1'b0;
         lock_oh_d = '0;
         count_d   = '0;
      end else begin
         if (cdb_valid_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
               if (entries_q[i].src1_tag == cdb_tag_i) entries_d[i].src1_rdy = 1'b1;
               if (entries_q[i].src2_tag == cdb_tag_i) entries_d[i].src2_rdy = 1'b1;
            end
         end
         if (issue_fire) begin
            for (int i = 0; i < ENTRIES; i++) begin
               if (sel_oh[i]) entries_d[i].valid = 1'b0;
            end
            lock_d    = 1'b0;
            lock_oh_d = '0;
         end else if (issue_valid_o) begin
            lock_d    = 1'b1;
            lock_oh_d = sel_oh;
         end
         // A broadcast in the allocation cycle is folded into the new entry.
         if (alloc_fire) begin
            for (int i = 0; i < ENTRIES; i++) begin
               if (alloc_oh[i]) begin
                  entries_d[i] = '{
                     valid:    1'b1,
                     src1_tag: alloc_src1_tag_i,
                     src1_rdy: alloc_src1_rdy_i | (cdb_valid_i && (cdb_tag_i == alloc_src1_tag_i)),
                     src2_tag: alloc_src2_tag_i,
                     src2_rdy: alloc_src2_rdy_i | (cdb_valid_i && (cdb_tag_i == alloc_src2_tag_i)),
                     payload:  alloc_payload_i
                  };
               end
            end
         end
         count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < ENTRIES; i++) entries_q[i].valid <= 1'b0;
         lock_q    <= 1'b0;
         lock_oh_q <= '0;
         count_q   <= '0;
      end else begin
         entries_q <= entries_d;
         lock_q    <= lock_d;
         lock_oh_q <= lock_oh_d;
         count_q   <= count_d;
      end
   end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench for rs_issue_scheduler: an age-by-sequence-number model
// checked against the DUT every cycle, plus hand-computed literal expectations.
module tb_rs_issue_scheduler;

   localparam int N  = 4;
   localparam int TW = 4;
   localparam int PW = 32;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          flush_i = 1'b0;
   logic          alloc_valid_i = 1'b0;
   logic          alloc_ready_o;
   logic [TW-1:0] alloc_src1_tag_i = '0;
   logic          alloc_src1_rdy_i = 1'b0;
   logic [TW-1:0] alloc_src2_tag_i = '0;
   logic          alloc_src2_rdy_i = 1'b0;
   logic [PW-1:0] alloc_payload_i = '0;
   logic          cdb_valid_i = 1'b0;
   logic [TW-1:0] cdb_tag_i = '0;
   logic          issue_valid_o;
   logic          issue_ready_i = 1'b0;
   logic [PW-1:0] issue_payload_o;
   logic [N-1:0]  issue_entry_o;
   logic [CW-1:0] count_o;

   always #5 clk = ~clk;

   rs_issue_scheduler dut (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .flush_i          (flush_i),
      .alloc_valid_i    (alloc_valid_i),
      .alloc_ready_o    (alloc_ready_o),
      .alloc_src1_tag_i (alloc_src1_tag_i),
      .alloc_src1_rdy_i (alloc_src1_rdy_i),
      .alloc_src2_tag_i (alloc_src2_tag_i),
      .alloc_src2_rdy_i (alloc_src2_rdy_i),
      .alloc_payload_i  (alloc_payload_i),
      .cdb_valid_i      (cdb_valid_i),
      .cdb_tag_i        (cdb_tag_i),
      .issue_valid_o    (issue_valid_o),
      .issue_ready_i    (issue_ready_i),
      .issue_payload_o  (issue_payload_o),
      .issue_entry_o    (issue_entry_o),
      .count_o          (count_o)
   );

   int errors = 0;
   int checks = 0;

   // Behavioural model: slots with an allocation sequence number for age.
   bit            m_valid [N];
   logic [TW-1:0] m_t1 [N];
   logic [TW-1:0] m_t2 [N];
   bit            m_r1 [N];
   bit            m_r2 [N];
   logic [PW-1:0] m_pay [N];
   int            m_seq [N];
   int            seq_ctr = 0;
   bit            m_lock = 1'b0;
   int            m_lock_idx = 0;
   bit            model_on = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_cnt();
      int c = 0;
      for (int i = 0; i < N; i++) if (m_valid[i]) c++;
      return c;
   endfunction

   function automatic int model_sel();
      int s = -1;
      if (m_lock) return m_lock_idx;
      for (int i = 0; i < N; i++) begin
         if (m_valid[i] && m_r1[i] && m_r2[i] && (s < 0 || m_seq[i] < m_seq[s])) s = i;
      end
      return s;
   endfunction

   // Model state advance on every active edge, using the inputs the DUT samples.
   always @(posedge clk) begin
      int s, k;
      bit v, rdy;
      if (reset_i) begin
         for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
         m_lock   = 1'b0;
         model_on = 1'b1;
      end else if (model_on) begin
         if (flush_i) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            m_lock = 1'b0;
         end else begin
            s   = model_sel();
            v   = (s >= 0);
            rdy = (model_cnt() < N);
            k   = -1;
            for (int i = 0; i < N; i++) if (!m_valid[i] && k < 0) k = i;
            if (cdb_valid_i) begin
               for (int i = 0; i < N; i++) begin
                  if (m_valid[i] && m_t1[i] == cdb_tag_i) m_r1[i] = 1'b1;
                  if (m_valid[i] && m_t2[i] == cdb_tag_i) m_r2[i] = 1'b1;
               end
            end
            if (v && issue_ready_i) begin
               m_valid[s] = 1'b0;
               m_lock     = 1'b0;
            end else if (v) begin
               m_lock     = 1'b1;
               m_lock_idx = s;
            end
            if (alloc_valid_i && rdy) begin
               m_valid[k] = 1'b1;
               m_t1[k]    = alloc_src1_tag_i;
               m_t2[k]    = alloc_src2_tag_i;
               m_r1[k]    = alloc_src1_rdy_i || (cdb_valid_i && cdb_tag_i == alloc_src1_tag_i);
               m_r2[k]    = alloc_src2_rdy_i || (cdb_valid_i && cdb_tag_i == alloc_src2_tag_i);
               m_pay[k]   = alloc_payload_i;
               m_seq[k]   = seq_ctr;
               seq_ctr++;
            end
         end
      end
   end

   // Compare process: every cycle, mid-period.
   always @(negedge clk) begin
      int s;
      if (model_on) begin
         s = model_sel();
         chk("issue_valid", 64'(issue_valid_o), 64'(s >= 0 && !flush_i));
         chk("issue_entry", 64'(issue_entry_o), (s >= 0) ? 64'(1 << s) : 64'(0));
         chk("issue_payload", 64'(issue_payload_o), (s >= 0) ? 64'(m_pay[s]) : 64'(0));
         chk("count", 64'(count_o), 64'(model_cnt()));
         chk("alloc_ready", 64'(alloc_ready_o), 64'(model_cnt() < N));
      end
   end

   // Close the current cycle and drop one-shot inputs.
   task automatic next();
      @(posedge clk);
      #1;
      alloc_valid_i = 1'b0;
      cdb_valid_i   = 1'b0;
      flush_i       = 1'b0;
      reset_i       = 1'b0;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic alloc(input logic [TW-1:0] t1, input bit r1, input logic [TW-1:0] t2,
                        input bit r2, input logic [PW-1:0] p);
      alloc_valid_i    = 1'b1;
      alloc_src1_tag_i = t1;
      alloc_src1_rdy_i = r1;
      alloc_src2_tag_i = t2;
      alloc_src2_rdy_i = r2;
      alloc_payload_i  = p;
   endtask

   task automatic cdb(input logic [TW-1:0] t);
      cdb_valid_i = 1'b1;
      cdb_tag_i   = t;
   endtask

   task automatic reset_values(input string tag);
      chk({tag, "_valid"}, 64'(issue_valid_o), 64'(0));
      chk({tag, "_entry"}, 64'(issue_entry_o), 64'(0));
      chk({tag, "_payload"}, 64'(issue_payload_o), 64'(0));
      chk({tag, "_count"}, 64'(count_o), 64'(0));
      chk({tag, "_alloc_ready"}, 64'(alloc_ready_o), 64'(1));
   endtask

   task automatic do_reset();
      reset_i       = 1'b1;
      flush_i       = 1'b0;
      alloc_valid_i = 1'b0;
      cdb_valid_i   = 1'b0;
      issue_ready_i = 1'b0;
      next();
      settle();
      reset_values("rst");
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Test 1: in-order issue of ready ops, one cycle after each allocation.
      do_reset();
      issue_ready_i = 1'b1;
      alloc(0, 1, 0, 1, 32'h11); settle();
      chk("t1_no_bypass", 64'(issue_valid_o), 64'(0));
      next();
      alloc(0, 1, 0, 1, 32'h22); settle();
      chk("t1_op0_pay", 64'(issue_payload_o), 64'h11);
      chk("t1_op0_ent", 64'(issue_entry_o), 64'b0001);
      next();
      alloc(0, 1, 0, 1, 32'h33); settle();
      chk("t1_op1_pay", 64'(issue_payload_o), 64'h22);
      chk("t1_op1_ent", 64'(issue_entry_o), 64'b0010);
      next();
      settle();
      chk("t1_op2_pay", 64'(issue_payload_o), 64'h33);
      chk("t1_op2_ent", 64'(issue_entry_o), 64'b0001);
      next();
      settle();
      chk("t1_empty_valid", 64'(issue_valid_o), 64'(0));
      chk("t1_empty_count", 64'(count_o), 64'(0));
      next();

      // Test 2: younger ready op bypasses an older waiting op; wakeup releases it.
      do_reset();
      issue_ready_i = 1'b1;
      alloc(5, 0, 0, 1, 32'hA); settle(); next();
      alloc(0, 1, 0, 1, 32'hB); settle(); next();
      settle();
      chk("t2_b_first", 64'(issue_payload_o), 64'hB);
      chk("t2_b_ent", 64'(issue_entry_o), 64'b0010);
      next();
      cdb(5); settle();
      chk("t2_a_waiting", 64'(issue_valid_o), 64'(0));
      next();
      settle();
      chk("t2_a_pay", 64'(issue_payload_o), 64'hA);
      chk("t2_a_ent", 64'(issue_entry_o), 64'b0001);
      next();
      settle(); next();

      // Test 3: full station, freeing, and simultaneous alloc+issue.
      do_reset();
      issue_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         alloc(0, 1, 0, 1, 32'h31 + 32'(i)); settle(); next();
      end
      alloc(0, 1, 0, 1, 32'h99); settle();
      chk("t3_full_ready", 64'(alloc_ready_o), 64'(0));
      chk("t3_full_count", 64'(count_o), 64'(4));
      next();
      issue_ready_i = 1'b1; settle();
      chk("t3_issue_e0", 64'(issue_payload_o), 64'h31);
      next();
      alloc(0, 1, 0, 1, 32'h35); settle();
      chk("t3_ready_again", 64'(alloc_ready_o), 64'(1));
      chk("t3_count3", 64'(count_o), 64'(3));
      chk("t3_issue_e1", 64'(issue_payload_o), 64'h32);
      next();
      issue_ready_i = 1'b0;
      alloc(0, 1, 0, 1, 32'h36); settle();
      chk("t3_count_kept", 64'(count_o), 64'(3));
      next();
      issue_ready_i = 1'b1;
      alloc(0, 1, 0, 1, 32'h37); settle();
      chk("t3_refull", 64'(count_o), 64'(4));
      chk("t3_issue_e2", 64'(issue_payload_o), 64'h33);
      next();
      settle();
      chk("t3_after_full_issue", 64'(count_o), 64'(3));
      next();

      // Test 4: held presentation survives an older entry waking.
      do_reset();
      issue_ready_i = 1'b0;
      alloc(6, 0, 0, 1, 32'h4A); settle(); next();
      alloc(0, 1, 0, 1, 32'h4B); settle(); next();
      settle();
      chk("t4_hold1_pay", 64'(issue_payload_o), 64'h4B);
      next();
      cdb(6); settle();
      chk("t4_hold2_pay", 64'(issue_payload_o), 64'h4B);
      next();
      settle();
      chk("t4_hold3_pay", 64'(issue_payload_o), 64'h4B);
      chk("t4_hold3_ent", 64'(issue_entry_o), 64'b0010);
      next();
      issue_ready_i = 1'b1; settle();
      chk("t4_b_accept", 64'(issue_payload_o), 64'h4B);
      next();
      settle();
      chk("t4_a_pay", 64'(issue_payload_o), 64'h4A);
      chk("t4_a_ent", 64'(issue_entry_o), 64'b0001);
      next();
      settle(); next();

      // Test 5: broadcast in the allocation cycle marks the source ready.
      do_reset();
      issue_ready_i = 1'b1;
      alloc(0, 1, 9, 0, 32'h55); cdb(9); settle(); next();
      alloc(0, 1, 3, 0, 32'h56); cdb(4); settle();
      chk("t5_same_cycle_wake", 64'(issue_payload_o), 64'h55);
      next();
      settle();
      chk("t5_wrong_tag_wait", 64'(issue_valid_o), 64'(0));
      chk("t5_count1", 64'(count_o), 64'(1));
      next();
      cdb(3); settle(); next();
      settle();
      chk("t5_woken", 64'(issue_payload_o), 64'h56);
      next();

      // Test 6: flush squashes everything; reset mid-hold.
      do_reset();
      issue_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         alloc(0, 1, 0, 1, 32'h60 + 32'(i)); settle(); next();
      end
      flush_i = 1'b1; issue_ready_i = 1'b1;
      alloc(0, 1, 0, 1, 32'h6F); settle();
      chk("t6_flush_no_issue", 64'(issue_valid_o), 64'(0));
      chk("t6_flush_count_pre", 64'(count_o), 64'(3));
      next();
      settle();
      chk("t6_flushed_count", 64'(count_o), 64'(0));
      chk("t6_flushed_valid", 64'(issue_valid_o), 64'(0));
      next();
      issue_ready_i = 1'b0;
      alloc(0, 1, 0, 1, 32'h61); settle(); next();
      alloc(0, 1, 0, 1, 32'h62); settle();
      chk("t6_present", 64'(issue_payload_o), 64'h61);
      next();
      reset_i = 1'b1; settle();
      chk("t6_held_ent", 64'(issue_entry_o), 64'b0001);
      next();
      settle();
      reset_values("t6_rst");
      next();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
